writeback_unit: RTL
===================

# writeback_unit

Parametrised writeback stage for the RV32 pipeline. It sits between the MEM stage and the register file. It selects the writeback source (ALU, data memory, PC+4, optional CSR) and formats load data (byte/half extraction, sign/zero extension). It absorbs variable-latency data-memory responses with a valid/ready handshake and a stall output, and issues one registered register-file write per accepted instruction.

## Interface
- XLEN, 32, datapath width; 32 or 64
- SEL_W, 2, width of source-select field
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  MEM stage presents an instruction
- in_ready  output  1  unit can accept; high only in IDLE
- sel_wb  input  SEL_W  00 ALU, 01 memory, 10 PC+4, 11 CSR (see Configuration)
- funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- addr_lo  input  2  byte offset of the load address
- rd  input  5  destination register
- reg_write  input  1  instruction writes rd
- alu_out, pc_next_mem, csr_rdata  input  XLEN  candidate sources
- dm_rvalid  input  1  data-memory response valid
- dm_rdata  input  XLEN  raw memory word
- flush  input  1  kill the instruction held or being accepted
- stall  output  1  high while a load waits for its response
- rf_we  output  1  register-file write enable, one-cycle pulse
- rf_waddr  output  5  write address
- rf_wdata  output  XLEN  write data

## Operation
- States: IDLE, WAIT_MEM, DRAIN. Reset → IDLE. rf_we=0, rf_waddr=0, rf_wdata=0, stall=0.
- IDLE, in_valid & !flush, sel_wb≠01: register the selected source. The next cycle gives rf_we=reg_write&(rd≠0). State stays IDLE.
- IDLE, in_valid & !flush, sel_wb=01: latch rd, reg_write, funct3 and addr_lo.
  - If dm_rvalid is high in the same cycle, use it and write next cycle; state stays IDLE.
  - Otherwise go to WAIT_MEM.
- WAIT_MEM: stall=1, in_ready=0.
  - dm_rvalid: format the data, write next cycle, go to IDLE.
  - flush without dm_rvalid: go to DRAIN, no write.
  - flush with dm_rvalid: go to IDLE, no write.
- DRAIN: stall=1, in_ready=0. Wait for the orphan dm_rvalid, discard it, go to IDLE.
- dm_rvalid in IDLE with no accepted load: ignored.
- flush in IDLE: the offered instruction is not accepted and produces no write.
- Load formatting: byte lane = addr_lo, half lane = addr_lo[1].
  - LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
  - LW passes the low 32 bits, sign-extended when XLEN=64.
- Misaligned LH/LW (addr_lo[0] set, or addr_lo≠0 for LW) use the lane given by the truncated offset. Misalignment is not flagged; trapping is upstream.
- Unlisted funct3 values behave as LW.
- rd=0 never asserts rf_we. rf_wdata still updates.

## Timing
- Non-load latency: 1 cycle from the accept edge to rf_we.
- Load latency: 1 cycle after the edge where dm_rvalid is sampled.
- Throughput: 1 instruction/cycle for non-loads and zero-wait loads.
- rf_we is a single-cycle pulse. rf_waddr and rf_wdata hold their values until the next write.
- stall is combinational from state: high exactly in WAIT_MEM and DRAIN.
- rst mid-operation: next edge gives IDLE and all outputs 0. A pending response is not drained; the memory side is reset by the same rst.

## Configuration
- WB_CSR_SRC_EN defined: sel_wb=11 selects csr_rdata.
- WB_CSR_SRC_EN undefined: csr_rdata is unused, and sel_wb=11 selects alu_out, as the default case does.

## Test plan
- Reset, then ALU op: sel=00, alu_out=0x0000_1234, rd=5 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234. All outputs 0 during rst.
- Zero-wait loads: dm_rdata=0x80FF_7F01 with dm_rvalid on accept:
  - LB, addr_lo=3 → 0xFFFF_FF80.
  - LBU, addr_lo=1 → 0x0000_007F.
  - LH, addr_lo=2 → 0xFFFF_80FF.
  - LHU, addr_lo=0 → 0x0000_7F01.
- Delayed load: LW accepted, dm_rvalid arrives 3 cycles later with 0xDEAD_BEEF → stall=1 and in_ready=0 for exactly 3 cycles, then rf_wdata=0xDEAD_BEEF one cycle after dm_rvalid.
- Flush in WAIT_MEM: flush one cycle after a load is accepted, dm_rvalid 2 cycles later → no rf_we, stall deasserts the cycle after dm_rvalid, and the following ALU op writes normally.
- rd=0 and PC+4: sel=10, rd=0 → rf_we stays 0. sel=10, rd=1, pc_next_mem=0x104 → rf_wdata=0x104.
- sel=11 with csr_rdata=0xAAAA, alu_out=0x5555 → 0xAAAA with WB_CSR_SRC_EN, 0x5555 without.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit -- RV32/RV64 pipeline writeback stage.
//
// Sits between the MEM stage and the register file. Picks the writeback
// source (ALU, data memory, PC+4, optionally CSR), formats load data
// (byte/half lane extraction, sign/zero extension) and absorbs
// variable-latency data-memory responses. Every accepted instruction
// produces exactly one registered register-file write slot.
//
// Optional feature macro: WB_CSR_SRC_EN
//   defined   -> sel_wb=11 selects csr_rdata
//   undefined -> csr_rdata is unused, sel_wb=11 selects alu_out
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid / in_ready            MEM-stage handshake (see below)
//   sel_wb, funct3, addr_lo        source select, load type, byte offset
//   rd, reg_write                  destination register and its write flag
//   alu_out, pc_next_mem, csr_rdata candidate writeback sources
//   dm_rvalid, dm_rdata            data-memory response
//   flush                          kill the held / offered instruction
//   stall                          high while a load waits for memory
//   rf_we, rf_waddr, rf_wdata      registered register-file write port
//   dbg_state                      current FSM state (0 IDLE, 1 WAIT_MEM, 2 DRAIN)
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both high and flush is low. in_ready depends only on state
// (high in IDLE), never on in_valid. dm_rvalid is a one-cycle response
// strobe with no back-pressure; it is only meaningful while a load is
// being accepted or is outstanding.

module writeback_unit #(
    parameter int XLEN  = 32,
    parameter int SEL_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SEL_W-1:0]    sel_wb,
    input  logic [2:0]          funct3,
    input  logic [1:0]          addr_lo,
    input  logic [4:0]          rd,
    input  logic                reg_write,
    input  logic [XLEN-1:0]     alu_out,
    input  logic [XLEN-1:0]     pc_next_mem,
    input  logic [XLEN-1:0]     csr_rdata,
    input  logic                dm_rvalid,
    input  logic [XLEN-1:0]     dm_rdata,
    input  logic                flush,
    output logic                stall,
    output logic                rf_we,
    output logic [4:0]          rf_waddr,
    output logic [XLEN-1:0]     rf_wdata,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] SEL_ALU = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_PC  = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_CSR = SEL_W'(3);

    state_t          state;
    logic [4:0]      ld_rd;
    logic            ld_we;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_addr_lo;
    logic [XLEN-1:0] src_data;

    // Lanes always come from the low 32-bit word; a misaligned half or word
    // simply uses the lane selected by the truncated offset.
    function automatic logic [XLEN-1:0] format_load(
        input logic [2:0]      f3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] raw
    );
        logic [31:0] word;
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [XLEN-1:0] res;
        word   = raw[31:0];
        byte_v = word[{off, 3'b000} +: 8];
        half_v = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = XLEN'($signed(byte_v));
            3'b001:  res = XLEN'($signed(half_v));
            3'b100:  res = XLEN'(byte_v);
            3'b101:  res = XLEN'(half_v);
            default: res = XLEN'($signed(word));   // LW and unlisted encodings
        endcase
        return res;
    endfunction

    always_comb begin
        src_data = alu_out;
        case (sel_wb)
            SEL_ALU: src_data = alu_out;
            SEL_PC:  src_data = pc_next_mem;
`ifdef WB_CSR_SRC_EN
            SEL_CSR: src_data = csr_rdata;
`else
            SEL_CSR: src_data = alu_out;
`endif
            default: src_data = alu_out;
        endcase
    end

`ifndef WB_CSR_SRC_EN
    logic csr_unused;
    assign csr_unused = ^csr_rdata;
`endif

    assign in_ready  = (state == IDLE);
    assign stall     = (state == WAIT_MEM) || (state == DRAIN);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rf_we      <= 1'b0;
            rf_waddr   <= 5'd0;
            rf_wdata   <= '0;
            ld_rd      <= 5'd0;
            ld_we      <= 1'b0;
            ld_funct3  <= 3'd0;
            ld_addr_lo <= 2'd0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        if (sel_wb != SEL_MEM) begin
                            rf_we    <= reg_write && (rd != 5'd0);
                            rf_waddr <= rd;
                            rf_wdata <= src_data;
                        end else begin
                            ld_rd      <= rd;
                            ld_we      <= reg_write;
                            ld_funct3  <= funct3;
                            ld_addr_lo <= addr_lo;
                            if (dm_rvalid) begin
                                // Zero-wait response: write straight from the inputs.
                                rf_we    <= reg_write && (rd != 5'd0);
                                rf_waddr <= rd;
                                rf_wdata <= format_load(funct3, addr_lo, dm_rdata);
                            end else begin
                                state <= WAIT_MEM;
                            end
                        end
                    end
                end
                WAIT_MEM: begin
                    if (dm_rvalid) begin
                        state <= IDLE;
                        if (!flush) begin
                            rf_we    <= ld_we && (ld_rd != 5'd0);
                            rf_waddr <= ld_rd;
                            rf_wdata <= format_load(ld_funct3, ld_addr_lo, dm_rdata);
                        end
                    end else if (flush) begin
                        // The response is still in flight; swallow it in DRAIN.
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dm_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
